// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
// -----------------------------------------------------------------------------
// Bank of NCH PWM channels sharing one period counter. Supports edge-aligned
// (sawtooth) and center-aligned (triangle) counting. Configuration is written
// into shadow registers and copied into the active registers at the end of
// each period, so a period in flight is never disturbed by a write. While the
// bank is disabled the active registers track the shadows every cycle.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-high; has priority over en and wr
//   en           : run enable; 0 stops, clears the counter and the outputs
//   mode         : 0 = edge-aligned, 1 = center-aligned (sampled at period end)
//   wr           : configuration write strobe
//   addr         : 0 = period, k in 1..NCH = duty of channel k-1, others ignored
//   wdata        : write data
//   pwm_mul      : registered PWM outputs, bit i = channel i
//   period_start : registered pulse, high in the cycle pwm_mul reflects cnt = 0
//
// Handshake: there is no back-pressure. A write is accepted on every rising
// edge where wr = 1 and reset = 0; an out-of-range address is dropped silently.
// -----------------------------------------------------------------------------
module pwm_bank #(
  parameter int          NCH        = 3,
  parameter int          WIDTH      = 16,
  parameter int unsigned PERIOD_RST = 99,
  parameter int          AW         = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [NCH-1:0]   pwm_mul,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] PERIOD_INIT = WIDTH'(PERIOD_RST);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  // Counter direction is the only piece of sequencing state.
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [0:0]       dir_q, dir_d;

  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] duty_sh_q [NCH];
  logic [WIDTH-1:0] duty_sh_d [NCH];

  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] duty_act_q [NCH];
  logic [WIDTH-1:0] duty_act_d [NCH];
  logic             mode_act_q, mode_act_d;

  logic [NCH-1:0]   pwm_q, pwm_d;
  logic             ps_q, ps_d;

  // ---------------------------------------------------------------------------
  // Configuration write decode
  // ---------------------------------------------------------------------------
  logic [31:0]    addr_ext;
  logic           wr_period;
  logic [NCH-1:0] wr_duty;

  assign addr_ext = 32'(addr);

  always_comb begin
    wr_period = wr && (addr_ext == 32'd0);
    for (int i = 0; i < NCH; i++) begin
      wr_duty[i] = wr && (addr_ext == 32'(i + 1));
    end
  end

  // Shadow next-state. The active registers load from these *_d values, which
  // forwards a write landing in the end-of-period cycle straight into the
  // next period.
  always_comb begin
    period_sh_d = wr_period ? wdata : period_sh_q;
    for (int i = 0; i < NCH; i++) begin
      duty_sh_d[i] = wr_duty[i] ? wdata : duty_sh_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  logic eop;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    eop   = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!mode_act_q) begin
      // Edge-aligned: 0 .. period_act, then wrap.
      dir_d = DIR_UP;
      if (cnt_q == period_act_q) begin
        eop   = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period_act_q) begin
        // A period of 0 or 1 has no down leg: the top is also the last cycle.
        if (period_act_q <= ONE) begin
          eop   = 1'b1;
          cnt_d = '0;
        end else begin
          dir_d = DIR_DOWN;
          cnt_d = period_act_q - ONE;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      // Down leg ends at 1; 0 belongs to the next period.
      if (cnt_q <= ONE) begin
        eop   = 1'b1;
        cnt_d = '0;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active register update: every cycle while disabled, else at period end.
  // ---------------------------------------------------------------------------
  logic load_act;

  assign load_act = !en || eop;

  always_comb begin
    period_act_d = load_act ? period_sh_d : period_act_q;
    mode_act_d   = load_act ? mode        : mode_act_q;
    for (int i = 0; i < NCH; i++) begin
      duty_act_d[i] = load_act ? duty_sh_d[i] : duty_act_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Comparators and output registers. cnt never exceeds period_act, so a
  // plain unsigned compare gives constant-high for duty > period without
  // any overflow concern, even when period_act is all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = en && (cnt_q < duty_act_q[i]);
    end
    ps_d = en && (cnt_q == '0) && (dir_q == DIR_UP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      period_sh_q  <= PERIOD_INIT;
      period_act_q <= PERIOD_INIT;
      mode_act_q   <= 1'b0;
      pwm_q        <= '0;
      ps_q         <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      mode_act_q   <= mode_act_d;
      pwm_q        <= pwm_d;
      ps_q         <= ps_d;
      for (int i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign pwm_mul      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank
// -----------------------------------------------------------------------------
// Self-checking bench for pwm_bank (NCH=3, WIDTH=16, AW=3 so that addresses
// above NCH can be presented). A phase-based reference model runs alongside
// every cycle; directed tables and hand-written sequences add explicit
// expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_pwm_bank;

  localparam int NCH   = 3;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             mode;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [NCH-1:0]   pwm_mul;
  logic             period_start;

  always #5 clk = ~clk;

  pwm_bank #(
    .NCH       (NCH),
    .WIDTH     (WIDTH),
    .PERIOD_RST(99),
    .AW        (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .pwm_mul     (pwm_mul),
    .period_start(period_start)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position within the period (phase) plus period length,
  // with the counter value derived from the phase.
  // ---------------------------------------------------------------------------
  int unsigned    m_psh, m_pact;
  int unsigned    m_dsh  [NCH];
  int unsigned    m_dact [NCH];
  bit             m_mact;
  longint         m_p;
  logic [NCH-1:0] m_pwm = '0;
  logic           m_ps  = 1'b0;

  function automatic longint per_len(input int unsigned p, input bit m);
    if (!m) return longint'(p) + 1;
    if (p == 0) return 1;
    return 2 * longint'(p);
  endfunction

  function automatic longint cnt_at(input longint ph, input int unsigned p, input bit m);
    if (!m || ph <= longint'(p)) return ph;
    return 2 * longint'(p) - ph;
  endfunction

  task automatic model_load();
    m_pact = m_psh;
    m_mact = mode;
    for (int i = 0; i < NCH; i++) m_dact[i] = m_dsh[i];
  endtask

  task automatic model_step();
    longint c;
    if (reset) begin
      m_psh  = 99;
      m_pact = 99;
      m_mact = 1'b0;
      m_p    = 0;
      m_pwm  = '0;
      m_ps   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_dsh[i]  = 0;
        m_dact[i] = 0;
      end
    end else begin
      if (wr) begin
        if (addr == 0) m_psh = wdata;
        else if (int'(addr) <= NCH) m_dsh[int'(addr) - 1] = wdata;
      end
      if (!en) begin
        m_p   = 0;
        m_pwm = '0;
        m_ps  = 1'b0;
        model_load();
      end else begin
        c = cnt_at(m_p, m_pact, m_mact);
        for (int i = 0; i < NCH; i++) m_pwm[i] = (c < longint'(m_dact[i]));
        m_ps = (m_p == 0);
        if (m_p == per_len(m_pact, m_mact) - 1) begin
          m_p = 0;
          model_load();
        end else begin
          m_p++;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic e, input logic m, input logic w,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    reset = r;
    en    = e;
    mode  = m;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_pwm", 32'(pwm_mul), 32'(m_pwm));
    check("model_ps", 32'(period_start), 32'(m_ps));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             en;
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [NCH-1:0]   exp_pwm;
    logic             exp_ps;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic w, input logic [AW-1:0] a,
                              input logic [WIDTH-1:0] d, input logic [NCH-1:0] ep,
                              input logic es);
    vec_t v;
    v.en = e; v.wr = w; v.addr = a; v.wdata = d; v.exp_pwm = ep; v.exp_ps = es;
    return v;
  endfunction

  int exp_c0 [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    // Period 9 with duties 2/5/10; mid-period duty0 -> 7; write period 5 on
    // the last cycle; out-of-range writes; en dropped at cnt=3 for 2 cycles.
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // cnt0
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b110, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b110, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b110, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));  // cnt9
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // 10: cnt0
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b110, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b110, 0));
    vecs.push_back(mk(1, 1, 1, 7, 3'b110, 0));  // cnt4: duty0 <- 7
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // 20: cnt0, duty0 now 7
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b101, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b101, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(mk(1, 1, 0, 5, 3'b100, 0));  // cnt9: period <- 5
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // 30: cnt0, 6-cycle period
    vecs.push_back(mk(1, 1, 4, 0, 3'b111, 0));  // addr 4 ignored
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b101, 0));  // cnt5
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // 36: cnt0
    vecs.push_back(mk(1, 1, 7, 1, 3'b111, 0));  // addr 7 ignored
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0));  // en dropped at cnt3
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 1));  // re-enable
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0));

    // Reset state
    cycle();
    cycle();
    check("reset_pwm", 32'(pwm_mul), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);

    // Configure while disabled
    drive(0, 0, 0, 1, 3'd0, 16'd9);  cycle();
    drive(0, 0, 0, 1, 3'd1, 16'd2);  cycle();
    drive(0, 0, 0, 1, 3'd2, 16'd5);  cycle();
    drive(0, 0, 0, 1, 3'd3, 16'd10); cycle();
    drive(0, 0, 0, 0, 3'd0, 16'd0);  cycle();

    foreach (vecs[k]) begin
      drive(1'b0, vecs[k].en, 1'b0, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      cycle();
      check($sformatf("vec%0d_pwm", k), 32'(pwm_mul), 32'(vecs[k].exp_pwm));
      check($sformatf("vec%0d_ps", k), 32'(period_start), 32'(vecs[k].exp_ps));
    end

    // Center-aligned: period 4, duty0 2 -> 8-cycle period.
    drive(0, 0, 1, 1, 3'd0, 16'd4); cycle();
    drive(0, 0, 1, 1, 3'd1, 16'd2); cycle();
    drive(0, 0, 1, 0, 3'd0, 16'd0); cycle();
    drive(0, 1, 1, 0, 3'd0, 16'd0);
    for (int k = 0; k < 36; k++) begin
      // Mode flips mid-period; must only take effect at the boundary (k=24).
      if (k == 19) drive(0, 1, 0, 0, 3'd0, 16'd0);
      cycle();
      if (k < 24) check($sformatf("center_c0_%0d", k), 32'(pwm_mul[0]), 32'(exp_c0[k % 8]));
      check($sformatf("mode_ps_%0d", k), 32'(period_start),
            32'((k == 0) || (k == 8) || (k == 16) || (k == 24) || (k == 29) || (k == 34)));
    end

    // Reset mid-period beats en and wr; period returns to 99, duties to 0.
    drive(1, 1, 0, 1, 3'd0, 16'd3); cycle();
    check("midreset_pwm", 32'(pwm_mul), 32'd0);
    check("midreset_ps", 32'(period_start), 32'd0);
    drive(0, 1, 0, 0, 3'd0, 16'd0);
    for (int k = 0; k < 201; k++) begin
      cycle();
      check($sformatf("rst_ps_%0d", k), 32'(period_start), 32'(k % 100 == 0));
      check($sformatf("rst_pwm_%0d", k), 32'(pwm_mul), 32'd0);
    end

    // All-ones period and duty: no wrap in the comparison.
    drive(0, 0, 0, 1, 3'd0, 16'hFFFF); cycle();
    drive(0, 0, 0, 1, 3'd1, 16'hFFFF); cycle();
    drive(0, 0, 0, 1, 3'd2, 16'hFFFE); cycle();
    drive(0, 1, 0, 0, 3'd0, 16'd0);
    for (int k = 0; k < 40; k++) begin
      cycle();
      check($sformatf("ones_%0d", k), 32'(pwm_mul[1:0]), 32'd3);
    end

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 3'd0, 16'd0); cycle();
    for (int k = 0; k < 4000; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      wr    = ($urandom_range(0, 3) == 0);
      addr  = a;
      wdata = (a == 0) ? WIDTH'($urandom_range(0, 12)) : WIDTH'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
